// File: rtl/conv_y_pool.sv
// conv_y_pool
//   Downstream stage of the convolution top. Takes one signed y sample per
//   valid/ready handshake, optionally clamps negatives to zero (ReLU), and
//   max-pools non-overlapping pairs within a frame of Y_COUNT samples. With an
//   odd Y_COUNT the final sample of a frame is emitted on its own. Results go
//   through a small first-word-fall-through FIFO to a valid/ready master port.
//   The final result of every frame carries an end-of-frame flag.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active high
//   s_valid_y    : upstream sample valid
//   s_ready_y    : sample accepted this cycle when s_valid_y is also high
//   s_data_in_y  : signed y sample, ACC_SIZE bits
//   m_valid_z    : pooled result valid (FIFO not empty)
//   m_ready_z    : downstream accepts the result
//   m_data_out_z : signed pooled result (0 while the FIFO is empty)
//   m_last_z     : marks the final result of a frame (0 while empty)

module conv_y_pool #(
  parameter int unsigned ACC_SIZE   = 21,
  parameter int unsigned Y_COUNT    = 97,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid_y,
  output logic                s_ready_y,
  input  logic [ACC_SIZE-1:0] s_data_in_y,
  output logic                m_valid_z,
  input  logic                m_ready_z,
  output logic [ACC_SIZE-1:0] m_data_out_z,
  output logic                m_last_z
);

  localparam int unsigned CNT_W  = (Y_COUNT > 1) ? $clog2(Y_COUNT) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(Y_COUNT - 1);
  localparam logic [FCNT_W-1:0] DEPTH    = FCNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [ACC_SIZE-1:0] hold_q, hold_d;

  // FIFO entry layout: {last, data}
  logic [ACC_SIZE:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic accept, pop, push;
  logic [ACC_SIZE:0] push_entry;

  // Ready depends on the registered count only, so there is no combinational
  // path from m_ready_z. A full FIFO stalls every input, even one that would
  // only fill the pair register.
  assign s_ready_y = !reset && (count_q < DEPTH);
  assign accept    = s_valid_y && s_ready_y;
  assign m_valid_z = (count_q != '0);
  assign pop       = m_valid_z && m_ready_z;

  // ---------------------------------------------------------------------------
  // ReLU and pair maximum
  // ---------------------------------------------------------------------------
  logic [ACC_SIZE-1:0] y_v;
  logic [ACC_SIZE-1:0] pair_max;
  logic                is_tail;

  assign y_v      = (RELU_EN && s_data_in_y[ACC_SIZE-1]) ? '0 : s_data_in_y;
  // Ties keep hold_q; the two values are identical in that case anyway.
  assign pair_max = ($signed(y_v) > $signed(hold_q)) ? y_v : hold_q;
  assign is_tail  = (in_cnt_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Pair FSM and frame counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    hold_d     = hold_q;
    push       = 1'b0;
    push_entry = '0;

    if (accept) begin
      in_cnt_d = is_tail ? '0 : in_cnt_q + CNT_W'(1);
      unique case (state_q)
        ST_EMPTY: begin
          if (is_tail) begin
            // Odd frame length: the last sample has no partner and leaves alone.
            push       = 1'b1;
            push_entry = {1'b1, y_v};
          end else begin
            hold_d  = y_v;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          push       = 1'b1;
          push_entry = {is_tail, pair_max};
          state_d    = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      in_cnt_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      hold_q   <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  // A push always comes from an accept, which already required count < DEPTH,
  // so a push is never issued against a full FIFO. A simultaneous push and pop
  // leaves the count unchanged while both pointers advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every read is qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  logic [ACC_SIZE:0] head;
  assign head         = m_valid_z ? fifo_q[rd_ptr_q] : '0;
  assign m_data_out_z = head[ACC_SIZE-1:0];
  assign m_last_z     = head[ACC_SIZE];

endmodule
